ts_buf_sched: RTL and testbench

- Scheduler and controller for the 10-bit symbol packing buffer. That buffer stores 10-bit TS symbols packed into 32-bit words, 21 words deep, and accepts one WRITE or READ command at a time.
- Arbitrates between one symbol producer and one symbol consumer.
- Issues single-cycle commands and enforces the buffer's busy time.
- Tracks symbol occupancy and returns read data with a valid strobe.
- Sits between the TS capture front end and the packing buffer.

---
 rtl/ts_buf_pkg.sv | 11 +
 rtl/ts_rr_arb2.sv | 37 +++
 rtl/ts_buf_sched.sv | 133 +++++++++++++
 tb/tb_ts_buf_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_buf_pkg.sv
// Shared types and default sizing for the TS symbol packing-buffer scheduler.
package ts_buf_pkg;

  localparam int unsigned SYM_W           = 10;
  localparam int unsigned DEF_CAPACITY    = 67;
  localparam int unsigned DEF_BUF_LATENCY = 2;

  typedef enum logic [1:0] {IDLE, CMD, BUSY} sched_state_t;
  typedef enum logic {OP_WR, OP_RD} op_t;

endpackage

// File: rtl/ts_rr_arb2.sv
// Two-requester picker (gnt[0] = write, gnt[1] = read). Ties alternate, or always go to
// the read when TS_SCHED_READ_PRIORITY_EN is defined.
module ts_rr_arb2
  import ts_buf_pkg::*;
(
  input  logic       elig_wr,
  input  logic       elig_rd,
  input  op_t        last,
  output logic [1:0] gnt
);

`ifdef TS_SCHED_READ_PRIORITY_EN
  logic unused_last;
  assign unused_last = (last == OP_RD);

  always_comb begin
    gnt = 2'b00;
    if (elig_rd) begin
      gnt = 2'b10;
    end else if (elig_wr) begin
      gnt = 2'b01;
    end
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (elig_wr && elig_rd) begin
      gnt = (last == OP_RD) ? 2'b01 : 2'b10;
    end else if (elig_wr) begin
      gnt = 2'b01;
    end else if (elig_rd) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/ts_buf_sched.sv
// Command scheduler for the 10-bit TS symbol packing buffer: arbitration, busy-time
// pacing, occupancy tracking. Define TS_SCHED_READ_PRIORITY_EN for fixed read priority.
module ts_buf_sched
  import ts_buf_pkg::*;
#(
  parameter int unsigned CAPACITY    = DEF_CAPACITY,
  parameter int unsigned BUF_LATENCY = DEF_BUF_LATENCY
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          WR_REQ,
  input  logic [SYM_W-1:0]              WR_DATA,
  output logic                          WR_ACK,
  input  logic                          RD_REQ,
  output logic                          RD_ACK,
  output logic [SYM_W-1:0]              RD_DATA,
  output logic                          RD_VALID,
  output logic                          BUF_WRITE,
  output logic                          BUF_READ,
  output logic [SYM_W-1:0]              BUF_DATA_IN,
  input  logic [SYM_W-1:0]              BUF_DATA_OUT,
  output logic [$clog2(CAPACITY+1)-1:0] FILL,
  output logic                          FULL,
  output logic                          EMPTY
);

  localparam int unsigned FILL_W = $clog2(CAPACITY + 1);
  localparam int unsigned CNT_W  = $clog2(BUF_LATENCY + 1);

  sched_state_t       state_q, state_d;
  op_t                op_q, op_d;
  op_t                last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [SYM_W-1:0]   buf_data_q, buf_data_d;
  logic [SYM_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               elig_wr, elig_rd;
  logic [1:0]         gnt;

  assign elig_wr = WR_REQ && (fill_q < FILL_W'(CAPACITY));
  assign elig_rd = RD_REQ && (fill_q != '0);

  ts_rr_arb2 u_arb (
    .elig_wr (elig_wr),
    .elig_rd (elig_rd),
    .last    (last_q),
    .gnt     (gnt)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    buf_data_d = buf_data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    WR_ACK     = 1'b0;
    RD_ACK     = 1'b0;
    BUF_WRITE  = 1'b0;
    BUF_READ   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          op_d       = OP_WR;
          buf_data_d = WR_DATA;
          state_d    = CMD;
        end else if (gnt[1]) begin
          op_d    = OP_RD;
          state_d = CMD;
        end
      end
      CMD: begin
        if (op_q == OP_WR) begin
          BUF_WRITE = 1'b1;
          WR_ACK    = 1'b1;
          fill_d    = fill_q + FILL_W'(1);
        end else begin
          BUF_READ = 1'b1;
          RD_ACK   = 1'b1;
          fill_d   = fill_q - FILL_W'(1);
        end
        last_d  = op_q;
        cnt_d   = CNT_W'(BUF_LATENCY);
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last busy cycle: buffer output is valid now, strobe it out next cycle.
        if (cnt_q == CNT_W'(1)) begin
          if (op_q == OP_RD) begin
            rd_data_d  = BUF_DATA_OUT;
            rd_valid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      op_q       <= OP_WR;
      last_q     <= OP_RD;
      cnt_q      <= '0;
      fill_q     <= '0;
      buf_data_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      buf_data_q <= buf_data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign FILL        = fill_q;
  assign FULL        = (fill_q == FILL_W'(CAPACITY));
  assign EMPTY       = (fill_q == '0);
  assign BUF_DATA_IN = buf_data_q;
  assign RD_DATA     = rd_data_q;
  assign RD_VALID    = rd_valid_q;

endmodule

// File: tb/tb_ts_buf_sched.sv
// Directed bench for ts_buf_sched: per-cycle vector table plus multi-cycle sequences
// against a behavioural packing buffer.
module tb_ts_buf_sched;

  localparam int unsigned CAP    = 67;
  localparam int          BUDGET = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_req, rd_req;
  logic [9:0] wr_data;
  logic       wr_ack, rd_ack, rd_valid, buf_write, buf_read, full, empty;
  logic [9:0] rd_data, buf_data_in, buf_data_out;
  logic [6:0] fill;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ts_buf_sched dut (
    .CLOCK        (clock),
    .RESET        (reset),
    .WR_REQ       (wr_req),
    .WR_DATA      (wr_data),
    .WR_ACK       (wr_ack),
    .RD_REQ       (rd_req),
    .RD_ACK       (rd_ack),
    .RD_DATA      (rd_data),
    .RD_VALID     (rd_valid),
    .BUF_WRITE    (buf_write),
    .BUF_READ     (buf_read),
    .BUF_DATA_IN  (buf_data_in),
    .BUF_DATA_OUT (buf_data_out),
    .FILL         (fill),
    .FULL         (full),
    .EMPTY        (empty)
  );

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Behavioural buffer: stores written symbols, presents one per read command.
  logic [9:0] mem_q[$];
  logic [9:0] bdo_mdl, bdo_tbl;
  logic       use_mdl = 1'b0;
  assign buf_data_out = use_mdl ? bdo_mdl : bdo_tbl;

  always @(posedge clock) begin
    if (reset) begin
      mem_q.delete();
      bdo_mdl <= '0;
    end else begin
      if (buf_write) mem_q.push_back(buf_data_in);
      if (buf_read && mem_q.size() > 0) bdo_mdl <= mem_q.pop_front();
    end
  end

  // Read-data scoreboard and per-cycle invariants.
  logic [9:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       inv_en = 1'b0;
  always @(negedge clock) begin
    logic [9:0] e;
    logic [3:0] cmd;
    if (mon_en) begin
      if (reset) begin
        exp_q.delete();
      end else begin
        if (wr_ack) exp_q.push_back(wr_data);
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            check("rd_valid_spurious", 34'(rd_valid), 34'd0);
          end else begin
            e = exp_q.pop_front();
            check("rd_data", 34'(rd_data), 34'(e));
          end
        end
      end
    end
    if (inv_en && !reset) begin
      cmd = {wr_ack, rd_ack, buf_write, buf_read};
      check("cmd_excl", 34'(cmd inside {4'b0000, 4'b1010, 4'b0101}), 34'd1);
      check("fill_range", 34'(fill <= 7'(CAP)), 34'd1);
      check("flags", {32'd0, full, empty}, {32'd0, fill == 7'(CAP), fill == 7'd0});
    end
  end

  typedef struct packed {
    logic        rst;
    logic        wq;
    logic [9:0]  wd;
    logic        rq;
    logic [9:0]  bdo;
    logic [33:0] want;
  } vec_t;

  // flg = {WR_ACK, RD_ACK, BUF_WRITE, BUF_READ, RD_VALID, FULL, EMPTY}
  function automatic vec_t mk(input logic rst, input logic wq, input logic [9:0] wd,
                              input logic rq, input logic [9:0] bdo, input logic [6:0] flg,
                              input logic [6:0] f, input logic [9:0] bdi, input logic [9:0] rdd);
    vec_t v;
    v.rst  = rst;
    v.wq   = wq;
    v.wd   = wd;
    v.rq   = rq;
    v.bdo  = bdo;
    v.want = {flg, f, bdi, rdd};
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Returns just after the command cycle; waited counts idle cycles before it.
  task automatic wait_cmd(output logic is_rd, output int waited, output logic [6:0] fill_at);
    logic done;
    done    = 1'b0;
    is_rd   = 1'b0;
    waited  = 0;
    fill_at = '0;
    while (!done && waited < BUDGET) begin
      @(negedge clock);
      if (buf_write || buf_read) begin
        is_rd   = buf_read;
        fill_at = fill;
        done    = 1'b1;
      end else begin
        waited++;
      end
      step();
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL cmd_timeout: buffer bus idle for %0d cycles, expected a command", BUDGET);
    end
  endtask

  task automatic do_write(input logic [9:0] d);
    logic r;
    int w;
    logic [6:0] f;
    wr_req  = 1'b1;
    wr_data = d;
    wait_cmd(r, w, f);
    check("wr_grant", 34'(r), 34'd0);
    wr_req = 1'b0;
  endtask

  task automatic do_read();
    logic r;
    int w;
    logic [6:0] f;
    rd_req = 1'b1;
    wait_cmd(r, w, f);
    check("rd_grant", 34'(r), 34'd1);
    rd_req = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    logic       r, exp_rd, mlast_rd;
    int         w, cnt;
    logic [6:0] f, mfill;

    tbl[0]  = mk(1, 0, 10'h000, 0, 10'h000, 7'b0000001, 7'd0, 10'h000, 10'h000);
    tbl[1]  = mk(0, 1, 10'h2A5, 0, 10'h000, 7'b0000001, 7'd0, 10'h000, 10'h000);
    tbl[2]  = mk(0, 1, 10'h2A5, 0, 10'h000, 7'b1010001, 7'd0, 10'h2A5, 10'h000);
    tbl[3]  = mk(0, 0, 10'h000, 1, 10'h000, 7'b0000000, 7'd1, 10'h2A5, 10'h000);
    tbl[4]  = mk(0, 0, 10'h000, 1, 10'h000, 7'b0000000, 7'd1, 10'h2A5, 10'h000);
    tbl[5]  = mk(0, 0, 10'h000, 1, 10'h000, 7'b0000000, 7'd1, 10'h2A5, 10'h000);
    tbl[6]  = mk(0, 0, 10'h000, 1, 10'h000, 7'b0101000, 7'd1, 10'h2A5, 10'h000);
    tbl[7]  = mk(0, 0, 10'h000, 0, 10'h000, 7'b0000001, 7'd0, 10'h2A5, 10'h000);
    tbl[8]  = mk(0, 0, 10'h000, 0, 10'h2A5, 7'b0000001, 7'd0, 10'h2A5, 10'h000);
    tbl[9]  = mk(0, 0, 10'h000, 0, 10'h000, 7'b0000101, 7'd0, 10'h2A5, 10'h2A5);
    tbl[10] = mk(0, 0, 10'h000, 0, 10'h000, 7'b0000001, 7'd0, 10'h2A5, 10'h2A5);
    tbl[11] = mk(0, 1, 10'h0F0, 1, 10'h000, 7'b0000001, 7'd0, 10'h2A5, 10'h2A5);
    tbl[12] = mk(0, 1, 10'h0F0, 1, 10'h000, 7'b1010001, 7'd0, 10'h0F0, 10'h2A5);

    reset   = 1'b1;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = '0;
    bdo_tbl = '0;
    step();
    inv_en = 1'b1;

    for (int i = 0; i < 13; i++) begin
      reset   = tbl[i].rst;
      wr_req  = tbl[i].wq;
      wr_data = tbl[i].wd;
      rd_req  = tbl[i].rq;
      bdo_tbl = tbl[i].bdo;
      @(negedge clock);
      check($sformatf("vec%0d", i),
            {wr_ack, rd_ack, buf_write, buf_read, rd_valid, full, empty, fill, buf_data_in,
             rd_data}, tbl[i].want);
      step();
    end

    use_mdl = 1'b1;
    mon_en  = 1'b1;

    // Both requests held from FILL=5 with a read served last.
    do_reset();
    for (int i = 0; i < 6; i++) do_write(10'(10'h100 + i));
    do_read();
    mfill    = 7'd5;
    mlast_rd = 1'b1;
    wr_data  = 10'h155;
    wr_req   = 1'b1;
    rd_req   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_cmd(r, w, f);
`ifdef TS_SCHED_READ_PRIORITY_EN
      exp_rd = (mfill > 0);
`else
      if (mfill > 0 && mfill < 7'(CAP)) exp_rd = !mlast_rd;
      else exp_rd = (mfill > 0);
`endif
      check($sformatf("alt_op%0d", k), 34'(r), 34'(exp_rd));
      check($sformatf("alt_fill%0d", k), 34'(f), 34'(mfill));
      if (k > 0) check($sformatf("alt_gap%0d", k), 34'(w), 34'd3);
      mfill    = exp_rd ? mfill - 7'd1 : mfill + 7'd1;
      mlast_rd = exp_rd;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;

    // Fill to capacity; a further write must wait for a read.
    do_reset();
    for (int i = 0; i < int'(CAP); i++) do_write(10'(i * 13));
    @(negedge clock);
    check("full_set", {25'd0, fill, full, empty}, {25'd0, 7'd67, 1'b1, 1'b0});
    step();
    wr_data = 10'h3FF;
    wr_req  = 1'b1;
    cnt     = 0;
    repeat (20) begin
      @(negedge clock);
      if (wr_ack || buf_write) cnt++;
      step();
    end
    check("full_block", 34'(cnt), 34'd0);
    do_read();
    @(negedge clock);
    check("full_clear", {26'd0, fill, full}, {26'd0, 7'd66, 1'b0});
    step();
    wait_cmd(r, w, f);
    check("full_pending_wr", 34'(r), 34'd0);
    wr_req = 1'b0;
    @(negedge clock);
    check("full_again", {26'd0, fill, full}, {26'd0, 7'd67, 1'b1});
    step();

    // Read request while empty is never granted.
    do_reset();
    rd_req = 1'b1;
    cnt    = 0;
    repeat (20) begin
      @(negedge clock);
      if (rd_ack || buf_read) cnt++;
      step();
    end
    check("empty_block", 34'(cnt), 34'd0);
    check("empty_flag", 34'(empty), 34'd1);
    rd_req = 1'b0;

    // Reset in the first busy cycle of a read drops it.
    do_reset();
    do_write(10'h3C3);
    do_read();
    reset = 1'b1;
    step();
    reset   = 1'b0;
    wr_data = 10'h111;
    wr_req  = 1'b1;
    @(negedge clock);
    check("rst_busy_state", {25'd0, fill, empty, rd_valid, buf_write},
          {25'd0, 7'd0, 1'b1, 1'b0, 1'b0});
    step();
    @(negedge clock);
    check("rst_busy_idle", {32'd0, wr_ack, rd_valid}, {32'd0, 1'b1, 1'b0});
    step();
    wr_req = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("rst_busy_novalid", 34'(rd_valid), 34'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
